// File: rtl/spi_slave_if.sv
// Register bus between a core and the SPI responder: single-cycle request,
// held by the requester until the acknowledge is seen.
interface spi_slave_if;
   logic        i_request;
   logic        i_rw;
   logic [1:0]  i_address;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_ready;

   modport master (
      output i_request, i_rw, i_address, i_wdata,
      input  o_rdata, o_ready
   );

   modport slave (
      input  i_request, i_rw, i_address, i_wdata,
      output o_rdata, o_ready
   );
endinterface

// File: rtl/spi_slave.sv
// SPI responder (CPOL = 0). All SPI pins are synchronised into i_clock; MOSI is
// deserialised into an RX FIFO and a TX FIFO is serialised onto MISO through a
// one-byte prefetch register. Register-mapped on the single-cycle-request bus.

// Byte queue with a registered read port: data appears the cycle after the read pulse.
module spi_slave_fifo #(
   parameter int DEPTH = 1024
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       write,
   input  logic [7:0] wdata,
   input  logic       read,
   output logic [7:0] rdata,
   output logic       empty,
   output logic       full,
   output logic       almost_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_wr;
   logic          do_rd;

   assign do_wr       = write & ~full;
   assign do_rd       = read & ~empty;
   assign empty       = (count == '0);
   assign full        = (count == CW'(DEPTH));
   assign almost_full = (count >= CW'(DEPTH - 1));

   // Storage array, no reset (RAM).
   always_ff @(posedge i_clock) begin
      if (do_wr) mem[wr_ptr] <= wdata;
   end

   // Pointers, occupancy and the registered read port.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
            rdata  <= mem[rd_ptr];
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module spi_slave #(
   parameter int FIFO_DEPTH = 1024
) (
   input  logic       i_clock,
   input  logic       i_reset,
   spi_slave_if.slave bus,
   output logic       o_rx_irq,
   input  logic       SPI_SS_n,
   input  logic       SPI_SCLK,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO
);
   typedef enum logic [1:0] {PF_IDLE, PF_WAIT, PF_LATCH} pf_state_t;
   typedef enum logic [1:0] {B_IDLE, B_WAIT, B_CAP, B_DONE} bus_state_t;

   logic [1:0] ss_sync, sclk_sync, mosi_sync;
   logic       sclk_d;
   logic       ss_active, sclk_s, mosi_s, sclk_rise, sclk_fall;
   logic [7:0] rx_shift, tx_shift;
   logic [2:0] bit_cnt;
   logic       tx_load, rx_push, rx_wr;
   logic       overflow, underrun, ovf_set, udr_set;
   logic [7:0] pf_data;
   logic       pf_valid, tx_read, pf_latch;
   pf_state_t  pf_state, pf_next;
   bus_state_t b_state, b_next;
   logic       rx_pop, tx_push, clr_ovf, clr_udr, rdata_load;
   logic [31:0] rdata_next, status;
   logic [7:0] rx_rdata, tx_rdata;
   logic       rx_empty, rx_full, rx_afull_unused;
   logic       tx_empty, tx_full, tx_afull;
   logic       unused_wdata;

   assign unused_wdata = ^bus.i_wdata[31:8];

   // Two-flop synchronisers on every pin plus a delayed SCLK copy for edge detection.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         ss_sync   <= 2'b11;
         sclk_sync <= 2'b00;
         mosi_sync <= 2'b00;
         sclk_d    <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[0], SPI_SS_n};
         sclk_sync <= {sclk_sync[0], SPI_SCLK};
         mosi_sync <= {mosi_sync[0], SPI_MOSI};
         sclk_d    <= sclk_sync[1];
      end
   end

   assign ss_active = ~ss_sync[1];
   assign sclk_s    = sclk_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;

   // A byte boundary is bit_cnt == 0: the rising edge there loads the next TX byte.
   assign tx_load  = ss_active & sclk_rise & (bit_cnt == 3'd0);
   assign rx_push  = ss_active & sclk_fall & (bit_cnt == 3'd7);
   assign rx_wr    = rx_push & ~rx_full;
   assign ovf_set  = rx_push & rx_full;
   assign udr_set  = tx_load & ~pf_valid;
   assign SPI_MISO = ss_active ? tx_shift[7] : 1'b0;
   assign o_rx_irq = ~rx_empty;

   // Serial shifters; SS deassert abandons any partial byte in both directions.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         rx_shift <= '0;
         tx_shift <= '0;
         bit_cnt  <= '0;
      end else if (!ss_active) begin
         rx_shift <= '0;
         tx_shift <= '0;
         bit_cnt  <= '0;
      end else if (sclk_fall) begin
         rx_shift <= {rx_shift[6:0], mosi_s};
         tx_shift <= {tx_shift[6:0], 1'b0};
         bit_cnt  <= bit_cnt + 3'd1;
      end else if (tx_load) begin
         tx_shift <= pf_valid ? pf_data : 8'hFF;
      end
   end

   // Sticky error flags; a set in the same cycle as a clear wins.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
         if (udr_set)      underrun <= 1'b1;
         else if (clr_udr) underrun <= 1'b0;
      end
   end

   // Prefetch register: latched by the FSM, consumed by a byte-boundary load.
   // A load during PF_LATCH sees pf_valid = 0, so the latched byte is kept.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         pf_valid <= 1'b0;
         pf_data  <= '0;
      end else if (pf_latch) begin
         pf_valid <= 1'b1;
         pf_data  <= tx_rdata;
      end else if (tx_load && pf_valid) begin
         pf_valid <= 1'b0;
      end
   end

   // Prefetch FSM state register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) pf_state <= PF_IDLE;
      else         pf_state <= pf_next;
   end

   // Prefetch FSM next state: read pulse, BRAM wait, latch.
   always_comb begin
      pf_next = pf_state;
      case (pf_state)
         PF_IDLE:  if (!pf_valid && !tx_empty) pf_next = PF_WAIT;
         PF_WAIT:  pf_next = PF_LATCH;
         PF_LATCH: pf_next = PF_IDLE;
         default:  pf_next = PF_IDLE;
      endcase
   end

   // Prefetch FSM outputs.
   always_comb begin
      tx_read  = (pf_state == PF_IDLE) && !pf_valid && !tx_empty;
      pf_latch = (pf_state == PF_LATCH);
   end

   assign status = {25'b0, pf_valid, ss_active, underrun, overflow,
                    rx_empty, tx_empty, tx_full};

   // Bus FSM state register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) b_state <= B_IDLE;
      else         b_state <= b_next;
   end

   // Bus FSM next state: address-0 accesses stall on RX empty / TX almost-full.
   always_comb begin
      b_next = b_state;
      case (b_state)
         B_IDLE: begin
            if (bus.i_request) begin
               if (bus.i_address != 2'd0)  b_next = B_DONE;
               else if (!bus.i_rw)         b_next = rx_empty ? B_IDLE : B_WAIT;
               else                        b_next = tx_afull ? B_IDLE : B_DONE;
            end
         end
         B_WAIT:  b_next = B_CAP;
         B_CAP:   b_next = B_DONE;
         B_DONE:  if (!bus.i_request) b_next = B_IDLE;
         default: b_next = B_IDLE;
      endcase
   end

   // Bus FSM outputs: FIFO strobes, flag clears and the read-data source.
   always_comb begin
      rx_pop     = 1'b0;
      tx_push    = 1'b0;
      clr_ovf    = 1'b0;
      clr_udr    = 1'b0;
      rdata_load = 1'b0;
      rdata_next = '0;
      if (b_state == B_IDLE && bus.i_request) begin
         if (bus.i_address == 2'd0) begin
            rx_pop  = !bus.i_rw && !rx_empty;
            tx_push = bus.i_rw && !tx_afull;
         end else if (bus.i_rw) begin
            clr_ovf = (bus.i_address == 2'd1) && bus.i_wdata[0];
            clr_udr = (bus.i_address == 2'd1) && bus.i_wdata[1];
         end else begin
            rdata_load = 1'b1;
            rdata_next = (bus.i_address == 2'd1) ? status : 32'd0;
         end
      end else if (b_state == B_CAP) begin
         rdata_load = 1'b1;
         rdata_next = {24'b0, rx_rdata};
      end
   end

   // Read-data register, updated only when a read completes.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)         bus.o_rdata <= '0;
      else if (rdata_load) bus.o_rdata <= rdata_next;
   end

   assign bus.o_ready = (b_state == B_DONE);

   spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .write       (rx_wr),
      .wdata       ({rx_shift[6:0], mosi_s}),
      .read        (rx_pop),
      .rdata       (rx_rdata),
      .empty       (rx_empty),
      .full        (rx_full),
      .almost_full (rx_afull_unused)
   );

   spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .write       (tx_push),
      .wdata       (bus.i_wdata[7:0]),
      .read        (tx_read),
      .rdata       (tx_rdata),
      .empty       (tx_empty),
      .full        (tx_full),
      .almost_full (tx_afull)
   );
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives the register bus and acts as the SPI master.
module tb_spi_slave;
   localparam int HALF = 6;

   logic i_clock = 1'b0;
   logic i_reset = 1'b1;
   logic o_rx_irq;
   logic SPI_SS_n = 1'b1;
   logic SPI_SCLK = 1'b0;
   logic SPI_MOSI = 1'b0;
   logic SPI_MISO;

   int errors = 0;
   int checks = 0;

   spi_slave_if bif ();

   spi_slave #(.FIFO_DEPTH(4)) dut (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .bus      (bif.slave),
      .o_rx_irq (o_rx_irq),
      .SPI_SS_n (SPI_SS_n),
      .SPI_SCLK (SPI_SCLK),
      .SPI_MOSI (SPI_MOSI),
      .SPI_MISO (SPI_MISO)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_xfer(input logic rw, input logic [1:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic ok);
      @(negedge i_clock);
      bif.i_request = 1'b1;
      bif.i_rw      = rw;
      bif.i_address = addr;
      bif.i_wdata   = wd;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge i_clock);
         if (bif.o_ready) begin
            ok = 1'b1;
            break;
         end
      end
      rd = bif.o_rdata;
      bif.i_request = 1'b0;
      @(negedge i_clock);
      @(negedge i_clock);
   endtask

   task automatic reg_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      logic        ok;
      bus_xfer(1'b0, addr, 32'd0, rd, ok);
      check({tag, "_rdy"}, {31'd0, ok}, 32'd1);
      check(tag, rd, exp);
   endtask

   task automatic reg_write(input string tag, input logic [1:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      logic        ok;
      bus_xfer(1'b1, addr, wd, rd, ok);
      check({tag, "_rdy"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic ss_begin();
      @(negedge i_clock);
      SPI_SS_n = 1'b0;
      repeat (HALF) @(negedge i_clock);
   endtask

   task automatic ss_end();
      repeat (HALF) @(negedge i_clock);
      SPI_SS_n = 1'b1;
      repeat (HALF) @(negedge i_clock);
   endtask

   // Data changes with SCLK rise, both ends sample just before SCLK falls.
   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         @(negedge i_clock);
         SPI_SCLK = 1'b1;
         SPI_MOSI = tx[7-i];
         repeat (HALF) @(negedge i_clock);
         rx[7-i] = SPI_MISO;
         SPI_SCLK = 1'b0;
         repeat (HALF - 1) @(negedge i_clock);
      end
   endtask

   initial begin
      logic [7:0]  r;
      logic        got;

      bif.i_request = 1'b0;
      bif.i_rw      = 1'b0;
      bif.i_address = 2'd0;
      bif.i_wdata   = 32'd0;

      // Reset state
      repeat (3) @(negedge i_clock);
      check("rst_ready", {31'd0, bif.o_ready}, 32'd0);
      check("rst_rdata", bif.o_rdata, 32'd0);
      check("rst_miso", {31'd0, SPI_MISO}, 32'd0);
      check("rst_irq", {31'd0, o_rx_irq}, 32'd0);
      i_reset = 1'b0;
      repeat (3) @(negedge i_clock);
      reg_read("rst_status", 2'd1, 32'h06);
      reg_read("addr2_read", 2'd2, 32'h0);
      reg_write("addr3_write", 2'd3, 32'hFFFF_FFFF);
      reg_read("addr3_read", 2'd3, 32'h0);

      // Full-duplex exchange with TX preloaded
      reg_write("tx_push0", 2'd0, 32'h81);
      reg_write("tx_push1", 2'd0, 32'h7E);
      repeat (10) @(negedge i_clock);
      reg_read("pre_status", 2'd1, 32'h44);
      ss_begin();
      spi_bits(8'hA5, 8, r);
      check("miso_b0", {24'd0, r}, 32'h81);
      spi_bits(8'h3C, 8, r);
      check("miso_b1", {24'd0, r}, 32'h7E);
      ss_end();
      check("irq_set", {31'd0, o_rx_irq}, 32'd1);
      reg_read("rx_b0", 2'd0, 32'hA5);
      reg_read("rx_b1", 2'd0, 32'h3C);
      check("irq_clr", {31'd0, o_rx_irq}, 32'd0);
      reg_read("post_status", 2'd1, 32'h06);

      // Underrun with TX empty, then write-1-to-clear
      ss_begin();
      spi_bits(8'h00, 8, r);
      check("udr_miso", {24'd0, r}, 32'hFF);
      ss_end();
      reg_read("udr_status", 2'd1, 32'h12);
      reg_write("udr_clr", 2'd1, 32'h2);
      reg_read("udr_cleared", 2'd1, 32'h02);
      reg_read("udr_rx", 2'd0, 32'h00);

      // RX overflow: 6 bytes into a 4-deep FIFO
      ss_begin();
      for (int b = 0; b < 6; b++) spi_bits(8'h11 + 8'(b), 8, r);
      ss_end();
      reg_read("ovf_status", 2'd1, 32'h1A);
      reg_read("ovf_rx0", 2'd0, 32'h11);
      reg_read("ovf_rx1", 2'd0, 32'h12);
      reg_read("ovf_rx2", 2'd0, 32'h13);
      reg_read("ovf_rx3", 2'd0, 32'h14);
      reg_write("ovf_clr", 2'd1, 32'h3);
      reg_read("ovf_cleared", 2'd1, 32'h06);

      // SS abort after 4 bits, then a full byte
      ss_begin();
      spi_bits(8'hA0, 4, r);
      ss_end();
      ss_begin();
      spi_bits(8'h55, 8, r);
      ss_end();
      reg_read("abort_status", 2'd1, 32'h12);
      reg_read("abort_rx", 2'd0, 32'h55);
      reg_read("abort_empty", 2'd1, 32'h16);
      reg_write("abort_clr", 2'd1, 32'h2);

      // Read stalls on empty RX until a byte arrives
      @(negedge i_clock);
      bif.i_request = 1'b1;
      bif.i_rw      = 1'b0;
      bif.i_address = 2'd0;
      repeat (20) @(negedge i_clock);
      check("stall_rdy", {31'd0, bif.o_ready}, 32'd0);
      ss_begin();
      spi_bits(8'h12, 8, r);
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bif.o_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge i_clock);
      end
      check("stall_done", {31'd0, got}, 32'd1);
      check("stall_data", bif.o_rdata, 32'h12);
      bif.i_request = 1'b0;
      @(negedge i_clock);
      @(negedge i_clock);
      check("stall_rdy_clr", {31'd0, bif.o_ready}, 32'd0);
      ss_end();
      reg_write("stall_clr", 2'd1, 32'h2);
      reg_read("stall_status", 2'd1, 32'h06);

      // Reset mid-byte
      reg_write("mid_push", 2'd0, 32'h99);
      repeat (8) @(negedge i_clock);
      ss_begin();
      spi_bits(8'hF0, 4, r);
      check("mid_nibble", {28'd0, r[7:4]}, 32'h9);
      @(negedge i_clock);
      SPI_SCLK = 1'b1;
      repeat (2) @(negedge i_clock);
      i_reset  = 1'b1;
      SPI_SS_n = 1'b1;
      SPI_SCLK = 1'b0;
      @(negedge i_clock);
      check("mid_miso", {31'd0, SPI_MISO}, 32'd0);
      check("mid_ready", {31'd0, bif.o_ready}, 32'd0);
      check("mid_irq", {31'd0, o_rx_irq}, 32'd0);
      repeat (2) @(negedge i_clock);
      i_reset = 1'b0;
      repeat (5) @(negedge i_clock);
      reg_read("mid_status", 2'd1, 32'h06);
      ss_begin();
      spi_bits(8'hC3, 8, r);
      check("mid_miso_ff", {24'd0, r}, 32'hFF);
      ss_end();
      reg_read("mid_rx", 2'd0, 32'hC3);
      reg_read("mid_final", 2'd1, 32'h16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
